// File: rtl/reg_file_mp.sv
// Multi-port register file: two byte-enabled write ports (port 1 has priority),
// NUM_READ combinational read ports with optional write bypass, and a post-reset clear sequencer.
module reg_file_mp #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_READ   = 2,
    parameter int BYPASS     = 1
) (
    input  logic                           clk,
    input  logic                           resetn,
    output logic                           ready,
    input  logic [DATA_WIDTH/8-1:0]        we0,
    input  logic [ADDR_WIDTH-1:0]          waddr0,
    input  logic [DATA_WIDTH-1:0]          wdata0,
    input  logic [DATA_WIDTH/8-1:0]        we1,
    input  logic [ADDR_WIDTH-1:0]          waddr1,
    input  logic [DATA_WIDTH-1:0]          wdata1,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] raddr,
    output logic [NUM_READ*DATA_WIDTH-1:0] rdata
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic {INIT, RUN} state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   cnt;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= INIT;
            cnt   <= ADDR_WIDTH'(1);
            ready <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == ADDR_WIDTH'(DEPTH - 1)) begin
                        state <= RUN;
                        ready <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Port 1 is written last so its bytes override port 0 on a collision.
    always_ff @(posedge clk) begin
        if (state == INIT) begin
            mem[cnt] <= '0;
        end else begin
            for (int b = 0; b < NB; b++) begin
                if (we0[b] && waddr0 != '0)
                    mem[waddr0][b*8 +: 8] <= wdata0[b*8 +: 8];
                if (we1[b] && waddr1 != '0)
                    mem[waddr1][b*8 +: 8] <= wdata1[b*8 +: 8];
            end
        end
    end

    for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
        logic [ADDR_WIDTH-1:0] ra;
        logic [DATA_WIDTH-1:0] rd;

        assign ra = raddr[k*ADDR_WIDTH +: ADDR_WIDTH];

        always_comb begin
            rd = mem[ra];
            if (BYPASS != 0) begin
                for (int b = 0; b < NB; b++) begin
                    if (we1[b] && waddr1 == ra)
                        rd[b*8 +: 8] = wdata1[b*8 +: 8];
                    else if (we0[b] && waddr0 == ra)
                        rd[b*8 +: 8] = wdata0[b*8 +: 8];
                end
            end
            // Entry 0 and every read during the clear sequence return zero.
            if (state != RUN || ra == '0)
                rd = '0;
        end

        assign rdata[k*DATA_WIDTH +: DATA_WIDTH] = rd;
    end

endmodule

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised multi-port register file, successor to the single-write-port CPU register file. It provides:
- configurable data width, depth and number of read ports;
- two byte-enabled write ports with fixed priority;
- optional same-cycle write-to-read bypass;
- a hardware clear sequencer that zeroes every entry after reset and signals completion on `ready`.

It sits in the decode/writeback stages of the pipelined CPU. Entry 0 always reads as zero.

## Interface
Parameters:
- `DATA_WIDTH`, default 32: entry width in bits. Must be a multiple of 8.
- `ADDR_WIDTH`, default 5: address width. Depth is DEPTH = 2^ADDR_WIDTH.
- `NUM_READ`, default 2: number of read ports, 1..4.
- `BYPASS`, default 1: 1 = read data reflects same-cycle writes; 0 = reads return stored contents only.

Ports (NB = DATA_WIDTH/8):
- `clk`  in  1  sole clock; all state updates on rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `ready`  out  1  high once the clear sequence has completed.
- `we0`  in  NB  byte write enables, write port 0.
- `waddr0`  in  ADDR_WIDTH  write address, port 0.
- `wdata0`  in  DATA_WIDTH  write data, port 0.
- `we1`  in  NB  byte write enables, write port 1 (higher priority).
- `waddr1`  in  ADDR_WIDTH  write address, port 1.
- `wdata1`  in  DATA_WIDTH  write data, port 1.
- `raddr`  in  NUM_READ*ADDR_WIDTH  flattened read addresses; port k occupies bits [k*ADDR_WIDTH +: ADDR_WIDTH].
- `rdata`  out  NUM_READ*DATA_WIDTH  flattened read data; port k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].

## Operation
State machine, two states: INIT and RUN. A clear counter `cnt` (ADDR_WIDTH bits) drives the clear sequence.

INIT:
- Each cycle writes 0 to entry `cnt`, then increments `cnt`.
- When `cnt == DEPTH-1`, that final entry is cleared and the state moves to RUN.
- `ready` = 0.
- Both write ports are ignored; writes presented in INIT are dropped, not queued.
- Every `rdata` lane is forced to 0.

RUN:
- `ready` = 1.
- Per byte lane b of entry a, the stored byte is updated at the rising edge as follows:
  - if `we1[b]` and `waddr1 == a`: take `wdata1` byte b;
  - else if `we0[b]` and `waddr0 == a`: take `wdata0` byte b;
  - otherwise hold.
- Port 1 wins per byte only. On an address collision, bytes enabled only on port 0 still land.
- Writes to address 0 are discarded on both ports.
- Read port k is combinational:
  - if `raddr_k == 0`: returns 0;
  - else if BYPASS = 1: each byte takes the value it will hold after this edge, applying the same priority as the write rule above;
  - else: returns the stored entry.

Reset:
- Asserting `resetn` low, at any time including mid-INIT, forces state = INIT, `cnt` = 1, `ready` = 0. The array is not reset directly.
- After `resetn` deasserts, the clear sequence restarts from entry 1.

Entry 0 needs no storage; it is hardwired to 0.

## Timing
- Reset values: `ready` = 0, `rdata` = all zeros, state = INIT, `cnt` = 1.
- Clear latency: `ready` rises DEPTH-1 rising edges after `resetn` deasserts. For the default parameters that is 31 edges.
- Write-to-read latency:
  - BYPASS = 1: 0 cycles, same cycle, combinational.
  - BYPASS = 0: 1 cycle, visible after the writing edge.
- The first write that lands is one presented in the same cycle `ready` reads 1.
- Combinational paths:
  - `raddr`/`we*`/`waddr*`/`wdata*` → `rdata` when BYPASS = 1;
  - `raddr` → `rdata` when BYPASS = 0.
  - `ready` is purely registered.
- `cnt` wraps only at the INIT→RUN transition. In RUN, `cnt` is held and unused.

## Test plan
- Reset/clear: pre-load entry 7 = 0xDEADBEEF, pulse `resetn` low, release → `ready` = 0 and `rdata` = 0 for 30 edges; `ready` = 1 after the 31st edge; entry 7 then reads 0x00000000.
- Byte-enable write: in RUN, write 0xFFFFFFFF to entry 3, then `we0` = 4'b0101, `wdata0` = 0x11223344 → entry 3 reads 0xFF22FF44.
- Port collision: `waddr0` = `waddr1` = 5, `we0` = 4'b1111 with 0xAAAAAAAA, `we1` = 4'b0011 with 0x0000BBBB → entry 5 reads 0xAAAABBBB.
- Bypass: BYPASS = 1, `raddr` port 0 = 9 while writing 0x12345678 to entry 9 → `rdata` port 0 = 0x12345678 in the same cycle. With BYPASS = 0 it shows the old value and switches to 0x12345678 on the next cycle.
- Register zero: write 0xFFFFFFFF to address 0 on both ports, and read address 0 on all read ports → all return 0 every cycle.
- Reset mid-INIT: assert `resetn` low at edge 10 of the clear sequence, release → `ready` rises exactly 31 edges after the second release, and writes attempted during INIT are absent afterwards.
